// File: rtl/bus_timer_pkg.sv
// bus_timer shared definitions: register map, bit indices, FSM states.
// Also holds the byte-lane merge helper used on register writes.
package bus_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_PEND = 0;
  localparam int ST_IRQ  = 1;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_WAIT,
    BUS_ACK,
    BUS_RELEASE
  } bus_state_t;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_ASSERTED,
    IRQ_RELEASE
  } irq_state_t;

  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// sel/ack memory bus between an initiator and a responder.
// The initiator holds sel_i and request fields until it samples ack_o.
interface bus_timer_if;
  logic        sel_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  wr_mask_i;
  logic [31:0] data_in_i;
  logic [31:0] data_out_o;
  logic        ack_o;

  modport master (
    output sel_i, addr_i, we_i, wr_mask_i, data_in_i,
    input  data_out_o, ack_o
  );

  modport slave (
    input  sel_i, addr_i, we_i, wr_mask_i, data_in_i,
    output data_out_o, ack_o
  );
endinterface

// File: rtl/bus_responder.sv
// Reusable sel/ack responder: optional wait states, one ack per request.
// commit_o strobes on the edge that raises ack_o; read data is sampled then.
module bus_responder
  import bus_timer_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 0
) (
  input  logic        clk,
  input  logic        reset_i,
  bus_timer_if.slave  bus,
  input  logic [31:0] rdata_i,
  output logic        commit_o,
  output logic [1:0]  addr_o,
  output logic        we_o,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o
);

  localparam logic [3:0] DLY_INIT =
    4'(ACK_DELAY == 0 ? 0 : ACK_DELAY - 1);

  bus_state_t  state_q, state_d;
  logic [3:0]  dly_q, dly_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  addr_q;
  logic        we_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic        live;
  logic        unused_addr;

  assign unused_addr = ^{bus.addr_i[31:4], bus.addr_i[1:0]};

  // In IDLE the request is taken straight off the bus so a
  // zero-delay commit sees it on the same edge.
  assign live    = (state_q == BUS_IDLE);
  assign addr_o  = live ? bus.addr_i[3:2] : addr_q;
  assign we_o    = live ? bus.we_i : we_q;
  assign mask_o  = live ? bus.wr_mask_i : mask_q;
  assign wdata_o = live ? bus.data_in_i : wdata_q;

  assign bus.ack_o      = (state_q == BUS_ACK);
  assign bus.data_out_o = data_q;

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    commit_o = 1'b0;
    data_d   = '0;
    unique case (state_q)
      BUS_IDLE: begin
        if (bus.sel_i) begin
          if (ACK_DELAY == 0) begin
            state_d  = BUS_ACK;
            commit_o = 1'b1;
          end else begin
            state_d = BUS_WAIT;
            dly_d   = DLY_INIT;
          end
        end
      end
      BUS_WAIT: begin
        if (dly_q == 4'd0) begin
          state_d  = BUS_ACK;
          commit_o = 1'b1;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      BUS_ACK: state_d = BUS_RELEASE;
      BUS_RELEASE: begin
        if (!bus.sel_i) state_d = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
    if (commit_o && !we_o) data_d = rdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= BUS_IDLE;
      dly_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      data_q  <= data_d;
      if (live && bus.sel_i) begin
        addr_q  <= bus.addr_i[3:2];
        we_q    <= bus.we_i;
        mask_q  <= bus.wr_mask_i;
        wdata_q <= bus.data_in_i;
      end
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with pending status and irq/eoi
// handshake; bus protocol handled by bus_responder.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 0,
  parameter int unsigned COUNT_W   = 32
) (
  input  logic       clk,
  input  logic       reset_i,
  bus_timer_if.slave bus,
  output logic       irq_o,
  input  logic       eoi_i
);

  localparam logic [COUNT_W-1:0] CNT_ONE =
    {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [2:0]         ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] load_q, load_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               pending_q, pending_d;
  irq_state_t         irq_state_q, irq_state_d;
  logic               eoi_q;

  logic        commit, req_we;
  logic [1:0]  req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic [31:0] rdata, old_w, new_w;
  logic        evt, req, clr_pend;

  bus_responder #(.ACK_DELAY(ACK_DELAY)) u_resp (
    .clk      (clk),
    .reset_i  (reset_i),
    .bus      (bus),
    .rdata_i  (rdata),
    .commit_o (commit),
    .addr_o   (req_addr),
    .we_o     (req_we),
    .mask_o   (req_mask),
    .wdata_o  (req_wdata)
  );

  assign irq_o = (irq_state_q == IRQ_ASSERTED);
  assign req   = pending_q & ctrl_q[CTRL_IRQ_EN];

  always_comb begin
    rdata = '0;
    unique case (req_addr)
      REG_CTRL:  rdata[2:0] = ctrl_q;
      REG_LOAD:  rdata[COUNT_W-1:0] = load_q;
      REG_COUNT: rdata[COUNT_W-1:0] = count_q;
      REG_STATUS: begin
        rdata[ST_PEND] = pending_q;
        rdata[ST_IRQ]  = irq_o;
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    irq_state_d = irq_state_q;
    clr_pend    = 1'b0;
    unique case (irq_state_q)
      IRQ_IDLE: begin
        if (req) irq_state_d = IRQ_ASSERTED;
      end
      IRQ_ASSERTED: begin
        if (eoi_i && !eoi_q) begin
          irq_state_d = IRQ_RELEASE;
          clr_pend    = 1'b1;
        end else if (eoi_i && !req) begin
          irq_state_d = IRQ_IDLE;
        end
      end
      IRQ_RELEASE: irq_state_d = IRQ_IDLE;
      default:     irq_state_d = IRQ_IDLE;
    endcase
  end

  // Later assignments win: bus writes over counter, events over clears.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    pending_d = pending_q;
    evt       = 1'b0;
    if (ctrl_q[CTRL_EN]) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_ONE;
      end else begin
        evt = 1'b1;
        if (ctrl_q[CTRL_AUTO]) count_d = load_q;
        else ctrl_d[CTRL_EN] = 1'b0;
      end
    end
    old_w = '0;
    unique case (req_addr)
      REG_CTRL:  old_w[2:0] = ctrl_d;
      REG_LOAD:  old_w[COUNT_W-1:0] = load_q;
      REG_COUNT: old_w[COUNT_W-1:0] = count_q;
      default:   old_w = '0;
    endcase
    new_w = merge_lanes(old_w, req_wdata, req_mask);
    if (commit && req_we) begin
      unique case (req_addr)
        REG_CTRL:  ctrl_d = new_w[2:0];
        REG_LOAD:  load_d = new_w[COUNT_W-1:0];
        REG_COUNT: count_d = new_w[COUNT_W-1:0];
        REG_STATUS: begin
          if (req_mask[0] && req_wdata[ST_PEND]) pending_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (clr_pend) pending_d = 1'b0;
    if (evt) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ctrl_q      <= '0;
      load_q      <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      irq_state_q <= IRQ_IDLE;
      eoi_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      load_q      <= load_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      irq_state_q <= irq_state_d;
      eoi_q       <= eoi_i;
    end
  end

endmodule
